// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_e;

  // Number of words the instruction memory can hold.
  function automatic logic [31:0] capacity(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write side of the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_reset;
  logic                  load_done;
  logic                  load_error;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error
  );
endinterface

// File: rtl/imem_word_packer.sv
// Packs bytes MSB-first into 32-bit words; word_ready marks the byte that completes a word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_en,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  logic [WORD_W-BYTE_W-1:0] shift_q;
  logic [IDX_W-1:0]         idx_q;

  // The completing byte is combined combinationally so the word is usable on its accept edge.
  assign word       = {shift_q, byte_in};
  assign word_ready = byte_en && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (byte_en) begin
      shift_q <= word[WORD_W-BYTE_W-1:0];
      idx_q   <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Frame parser that writes a checksum-protected image into instruction memory and releases
// the CPU from reset once the image is verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  state_e                state_q;
  logic [7:0]            count_hi_q;
  logic [15:0]           words_left_q;
  logic [ADDR_WIDTH-1:0] word_idx_q;
  logic [7:0]            csum_q;
  logic                  in_ready_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_W-1:0]     wdata_q;
  logic                  cpu_reset_q;
  logic                  done_q;
  logic                  error_q;

  logic              fire;
  logic              pack_en;
  logic              word_ready;
  logic [WORD_W-1:0] packed_word;
  logic [15:0]       count_w;
  logic              too_big;

  assign fire    = bus.in_valid && in_ready_q;
  assign pack_en = fire && (state_q == DATA);
  assign count_w = {count_hi_q, bus.in_data};
  assign too_big = 32'(count_w) > capacity(ADDR_WIDTH);

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (bus.in_data),
    .byte_en    (pack_en),
    .word       (packed_word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CNT_HI;
      count_hi_q   <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
      in_ready_q   <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (fire && (state_q != CHECK)) begin
        csum_q <= csum_q ^ bus.in_data;
      end
      if (fire) begin
        case (state_q)
          CNT_HI: begin
            count_hi_q <= bus.in_data;
            state_q    <= CNT_LO;
          end
          CNT_LO: begin
            words_left_q <= count_w;
            if (too_big) begin
              state_q    <= ERROR;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else if (count_w == 16'd0) begin
              state_q <= CHECK;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            if (word_ready) begin
              we_q         <= 1'b1;
              addr_q       <= word_idx_q;
              wdata_q      <= packed_word;
              word_idx_q   <= word_idx_q + ADDR_WIDTH'(1);
              words_left_q <= words_left_q - 16'd1;
              if (words_left_q == 16'd1) begin
                state_q <= CHECK;
              end
            end
          end
          CHECK: begin
            in_ready_q <= 1'b0;
            if (bus.in_data == csum_q) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.load_done  = done_q;
  assign bus.load_error = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frame table, reset sequences, random frames.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam int          S_RUN  = 0;
  localparam int          S_DONE = 1;
  localparam int          S_ERR  = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  typedef struct {
    logic [127:0] bytes;  // left-aligned, byte 0 in bits [127:120]
    int           len;
    int           gap;
    logic         exp_done;
    logic         exp_err;
    int           exp_nwr;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  bit   prev_we = 1'b0;
  wr_t  got_wr[$];
  wr_t  exp_wr[$];
  logic [31:0] mem [DEPTH];
  vec_t vecs [5];

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (bus.imem_we) begin
        check_bit("we_one_cycle", prev_we, 1'b0);
        got_wr.push_back('{addr: bus.imem_addr, data: bus.imem_wdata});
        mem[bus.imem_addr] = bus.imem_wdata;
      end
      prev_we = bus.imem_we;
    end
  end

  // Reference: interpret the frame byte list directly from the frame rules.
  function automatic int run_model(input bq_t s);
    int n;
    logic [7:0] x;
    exp_wr.delete();
    if (s.size() < 2) return S_RUN;
    n = int'({s[0], s[1]});
    if (n > DEPTH) return S_ERR;
    for (int w = 0; w < n; w++) begin
      if (s.size() < 2 + 4 * w + 4) return S_RUN;
      exp_wr.push_back('{addr: AW'(w),
                         data: {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]}});
    end
    if (s.size() < 3 + 4 * n) return S_RUN;
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= s[i];
    return (s[2+4*n] == x) ? S_DONE : S_ERR;
  endfunction

  function automatic bq_t make_frame(input int n, input bit corrupt);
    bq_t q;
    logic [15:0] c;
    logic [7:0]  x;
    logic [7:0]  b;
    c = 16'(n);
    q.push_back(c[15:8]);
    q.push_back(c[7:0]);
    if (n > DEPTH) begin
      for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
      return q;
    end
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      q.push_back(b);
    end
    x = 8'h00;
    foreach (q[i]) x ^= q[i];
    if (corrupt) x ^= 8'(1 + $urandom_range(0, 254));
    q.push_back(x);
    return q;
  endfunction

  // Called at a negedge; returns at the negedge after the last accepted byte.
  task automatic send_stream(input bq_t s, input int gap);
    foreach (s[i]) begin
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat ($urandom_range(1, gap)) @(negedge clk);
      end
      bus.in_data  = s[i];
      bus.in_valid = 1'b1;
      if (!bus.in_ready) begin
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset        = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got_wr.delete();
  endtask

  task automatic check_final(input string tag, input int st);
    check_bit({tag, "_done"}, bus.load_done, st == S_DONE);
    check_bit({tag, "_err"}, bus.load_error, st == S_ERR);
    check_bit({tag, "_cpurst"}, bus.cpu_reset, st != S_DONE);
    check_bit({tag, "_ready"}, bus.in_ready, st == S_RUN);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      check({tag, "_addr"}, 32'(got_wr[i].addr), 32'(exp_wr[i].addr));
      check({tag, "_data"}, got_wr[i].data, exp_wr[i].data);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_ready"}, bus.in_ready, 1'b1);
    check_bit({tag, "_we"}, bus.imem_we, 1'b0);
    check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check_bit({tag, "_cpurst"}, bus.cpu_reset, 1'b1);
    check_bit({tag, "_done"}, bus.load_done, 1'b0);
    check_bit({tag, "_err"}, bus.load_error, 1'b0);
  endtask

  function automatic bq_t vec_bytes(input vec_t v);
    bq_t q;
    for (int i = 0; i < v.len; i++) q.push_back(v.bytes[127-8*i -: 8]);
    return q;
  endfunction

  initial begin
    bq_t s;
    int  st;
    int  n;

    vecs[0] = '{{88'h0002200800052009000A0C, 40'h0}, 11, 0, 1'b1, 1'b0, 2,
                32'h20080005, 32'h2009000A};
    vecs[1] = '{{88'h0002200800052009000A0D, 40'h0}, 11, 0, 1'b0, 1'b1, 2,
                32'h20080005, 32'h2009000A};
    vecs[2] = '{{24'h000000, 104'h0}, 3, 0, 1'b1, 1'b0, 0, 32'h0, 32'h0};
    vecs[3] = '{{16'h0401, 112'h0}, 2, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[4] = '{{88'h0002200800052009000A0C, 40'h0}, 11, 3, 1'b1, 1'b0, 2,
                32'h20080005, 32'h2009000A};

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      send_stream(vec_bytes(vecs[v]), vecs[v].gap);
      check_bit($sformatf("v%0d_done_next", v), bus.load_done, vecs[v].exp_done);
      check_bit($sformatf("v%0d_err_next", v), bus.load_error, vecs[v].exp_err);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_nwr", v), 32'(got_wr.size()), 32'(vecs[v].exp_nwr));
      if (got_wr.size() > 0 && vecs[v].exp_nwr > 0) begin
        check($sformatf("v%0d_a0", v), 32'(got_wr[0].addr), 32'd0);
        check($sformatf("v%0d_w0", v), got_wr[0].data, vecs[v].w0);
      end
      if (got_wr.size() > 1 && vecs[v].exp_nwr > 1) begin
        check($sformatf("v%0d_a1", v), 32'(got_wr[1].addr), 32'd1);
        check($sformatf("v%0d_w1", v), got_wr[1].data, vecs[v].w1);
      end
      check_final($sformatf("v%0d", v),
                  vecs[v].exp_done ? S_DONE : (vecs[v].exp_err ? S_ERR : S_RUN));
    end

    // Reset mid-frame, then reload; reset must act without a clock edge.
    do_reset();
    s = vec_bytes(vecs[0]);
    send_stream(s[0:4], 0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    got_wr.delete();
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'hDEADBEEF;
    send_stream(s, 0);
    repeat (3) @(negedge clk);
    check("midrst_mem0", mem[0], 32'h20080005);
    check("midrst_mem1", mem[1], 32'h2009000A);
    check_final("midrst_reload", S_DONE);

    // Reset from DONE: registered outputs with non-reset values must clear asynchronously.
    #2 reset = 1'b1;
    #1 check_reset_outputs("donerst");
    @(negedge clk);
    reset = 1'b0;

    // Largest legal image fills the whole memory.
    do_reset();
    s  = make_frame(DEPTH, 1'b0);
    st = run_model(s);
    send_stream(s, 0);
    repeat (3) @(negedge clk);
    check_writes("full");
    check_final("full", st);

    for (int t = 0; t < 30; t++) begin
      do_reset();
      n = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) n = DEPTH + 1 + $urandom_range(0, 200);
      s  = make_frame(n, $urandom_range(0, 3) == 0);
      st = run_model(s);
      send_stream(s, $urandom_range(0, 3));
      repeat (3) @(negedge clk);
      check_writes($sformatf("rnd%0d", t));
      check_final($sformatf("rnd%0d", t), st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Synthesizable program loader; the writing side of the CPU instruction memory that the fetch stage reads.
- Accepts a framed byte stream over a valid/ready handshake, packs bytes into 32-bit words and writes them sequentially into instruction memory from word address 0.
- Holds the CPU in reset until a checksum-verified image has been fully written.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  word to write.
- cpu_reset  output  1  held high until the load completes.
- load_done  output  1  image loaded and verified.
- load_error  output  1  frame rejected.

Behaviour:
- Frame format:
  - COUNT_HI, COUNT_LO: word count N, big-endian, 16 bits.
  - N×4 data bytes, each word MSB first.
  - One checksum byte: XOR of every preceding frame byte, including the count bytes.
- Transfer rule: a byte transfers on a rising clk edge with in_valid && in_ready. Gaps in in_valid are allowed and transparent.
- Reset values: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0. State=CNT_HI, checksum accumulator=0, byte index=0.
- State CNT_HI: accept byte into count[15:8] -> CNT_LO.
- State CNT_LO: accept byte into count[7:0]. Next state:
  - ERROR if count > 2^ADDR_WIDTH;
  - else CHECK if count == 0;
  - else DATA.
- State DATA: shift bytes into the word register, MSB first.
  - On the 4th byte of a word, the next cycle drives imem_we=1 for exactly one cycle, with imem_wdata = assembled word and imem_addr = word index.
  - The word index increments after each write.
  - The write cycle does not stall input: in_ready stays 1, and a byte accepted in that cycle starts the next word.
  - After word N-1 is assembled -> CHECK.
- State CHECK: accept one byte and compare it with the accumulator.
  - Match -> DONE: load_done=1 and cpu_reset=0 from the next cycle.
  - Mismatch -> ERROR.
- in_ready: 1 in CNT_HI, CNT_LO, DATA, CHECK; 0 in DONE and ERROR.
- DONE and ERROR are terminal; only reset leaves them. In ERROR: load_error=1, cpu_reset stays 1, and no further writes occur.
- The last data-word write and the CHECK byte may fall in the same cycle; both take effect.
- Reset mid-frame: all state returns to reset values and the next byte is treated as COUNT_HI. Words already written remain in memory and are not cleared.
- imem_addr holds its last value between writes. Writes are never issued for address ≥ 2^ADDR_WIDTH.

Decomposition:
- Shared package imem_loader_pkg holds:
  - state encoding CNT_HI, CNT_LO, DATA, CHECK, DONE, ERROR;
  - byte width 8 and word width 32;
  - BYTES_PER_WORD = 4.
- One natural sub-module, imem_word_packer: a 4-byte MSB-first shift register with byte counter and a word_ready pulse. The top level contains the FSM, checksum, address counter and output registers.

Test Plan:
- Stream 00 02 20 08 00 05 20 09 00 0A 0C, continuous valid -> imem_we pulses twice: addr 0 data 0x20080005, then addr 1 data 0x2009000A. After the checksum: load_done=1, cpu_reset=0, in_ready=0.
- Same stream with last byte 0D -> both writes occur, then load_error=1, cpu_reset stays 1, load_done=0, in_ready=0.
- Stream 00 00 00 -> no imem_we pulses; load_done=1, cpu_reset=0.
- ADDR_WIDTH=10, stream 04 01 -> load_error=1 one cycle after COUNT_LO; zero writes; in_ready=0.
- Same stream as test 1 with in_valid low for 1–3 cycles between every byte -> identical write sequence and final state.
- Assert reset after the 5th byte of test 1, then send the full test-1 stream -> addr 0 rewritten with 0x20080005, addr 1 with 0x2009000A, load_done=1. Outputs show reset values immediately on the reset edge, without waiting for clk.
